// File: rtl/fp_pkg.sv
// Shared types and sizes for the single-precision add/sub datapath.
// fp_norm_t is the normalizer-to-rounder bundle.
package fp_pkg;

    localparam int SIZE_DATA  = 24;
    localparam int SIZE_EXP   = 8;
    localparam int SIZE_SHIFT = 5;
    localparam int EXP_MAX    = 255;

    typedef struct packed {
        logic                 sign;
        logic [SIZE_EXP-1:0]  exp;
        logic [SIZE_DATA-1:0] mant;
        logic                 sticky;
        logic                 zero;
        logic                 uf;
        logic                 of;
    } fp_norm_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; all-zero input yields SIZE_DATA.
module fp_lzc #(
    parameter int SIZE_DATA  = 24,
    parameter int SIZE_SHIFT = 5
) (
    input  logic [SIZE_DATA-1:0]  i_data,
    output logic [SIZE_SHIFT-1:0] o_count
);

    logic w_hit;

    always_comb begin
        w_hit   = 1'b0;
        o_count = SIZE_SHIFT'(SIZE_DATA);
        for (int i = SIZE_DATA - 1; i >= 0; i--) begin
            if (!w_hit && i_data[i]) begin
                o_count = SIZE_SHIFT'(SIZE_DATA - 1 - i);
                w_hit   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_norm_pipe.sv
// Two-stage post-add normalizer: S1 counts leading zeros, S2 shifts,
// adjusts the exponent and raises zero/underflow/overflow.
module fp_norm_pipe #(
    parameter int SIZE_DATA  = fp_pkg::SIZE_DATA,
    parameter int SIZE_EXP   = fp_pkg::SIZE_EXP,
    parameter int SIZE_SHIFT = fp_pkg::SIZE_SHIFT
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_sign,
    input  logic [SIZE_EXP-1:0]  i_exp,
    input  logic [SIZE_DATA:0]   i_mant,
    input  logic                 i_sticky,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_sign,
    output logic [SIZE_EXP-1:0]  o_exp,
    output logic [SIZE_DATA-1:0] o_mant,
    output logic                 o_sticky,
    output logic                 o_zero,
    output logic                 o_underflow,
    output logic                 o_overflow
);
    import fp_pkg::*;

    localparam int EW = SIZE_EXP + 1;

    logic                  r_v1;
    logic                  r_v2;
    logic                  r1_sign;
    logic [SIZE_EXP-1:0]   r1_exp;
    logic [SIZE_DATA:0]    r1_mant;
    logic                  r1_sticky;
    logic [SIZE_SHIFT-1:0] r1_lzc;
    fp_norm_t              r_out;

    logic                  w_s1_load;
    logic                  w_s2_load;
    logic [SIZE_SHIFT-1:0] w_lzc;
    logic [EW-1:0]         w_exp_x;
    logic [EW-1:0]         w_lzc_x;
    logic [EW-1:0]         w_exp_inc;
    logic [EW-1:0]         w_exp_dec;
    logic [SIZE_SHIFT-1:0] w_sub_sh;
    logic                  w_carry;
    logic                  w_is_zero;
    logic                  w_norm;
    logic                  w_sub;
    fp_norm_t              w_next;

    assign w_s2_load = !r_v2 || i_ready;
    assign w_s1_load = !r_v1 || w_s2_load;
    assign o_ready   = w_s1_load;

    fp_lzc #(
        .SIZE_DATA  (SIZE_DATA),
        .SIZE_SHIFT (SIZE_SHIFT)
    ) u_lzc (
        .i_data  (i_mant[SIZE_DATA-1:0]),
        .o_count (w_lzc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v1      <= 1'b0;
            r1_sign   <= 1'b0;
            r1_exp    <= '0;
            r1_mant   <= '0;
            r1_sticky <= 1'b0;
            r1_lzc    <= '0;
        end else if (w_s1_load) begin
            r_v1      <= i_valid;
            r1_sign   <= i_sign;
            r1_exp    <= i_exp;
            r1_mant   <= i_mant;
            r1_sticky <= i_sticky;
            r1_lzc    <= w_lzc;
        end
    end

    // Widened exponent math so the +1 and -lzc cannot wrap silently
    assign w_exp_x   = {1'b0, r1_exp};
    assign w_lzc_x   = {{(EW - SIZE_SHIFT){1'b0}}, r1_lzc};
    assign w_exp_inc = w_exp_x + EW'(1);
    assign w_exp_dec = w_exp_x - w_lzc_x;
    assign w_sub_sh  = (r1_exp == '0) ? '0 : SIZE_SHIFT'(r1_exp - 1'b1);

    assign w_carry   = r1_mant[SIZE_DATA];
    assign w_is_zero = (r1_mant == '0);
    assign w_norm    = !w_carry && !w_is_zero && (w_lzc_x < w_exp_x);
    assign w_sub     = !w_carry && !w_is_zero && !(w_lzc_x < w_exp_x);

    always_comb begin
        w_next      = '0;
        w_next.sign = r1_sign;
        unique case (1'b1)
            w_carry: begin
                if (w_exp_inc >= EW'(EXP_MAX)) begin
                    w_next.of  = 1'b1;
                    w_next.exp = SIZE_EXP'(EXP_MAX);
                end else begin
                    w_next.exp    = w_exp_inc[SIZE_EXP-1:0];
                    w_next.mant   = r1_mant[SIZE_DATA:1];
                    w_next.sticky = r1_sticky | r1_mant[0];
                end
            end
            w_is_zero: begin
                w_next.zero   = 1'b1;
                w_next.sticky = r1_sticky;
            end
            w_norm: begin
                w_next.exp    = w_exp_dec[SIZE_EXP-1:0];
                w_next.mant   = r1_mant[SIZE_DATA-1:0] << r1_lzc;
                w_next.sticky = r1_sticky;
            end
            w_sub: begin
                w_next.uf     = 1'b1;
                w_next.mant   = r1_mant[SIZE_DATA-1:0] << w_sub_sh;
                w_next.sticky = r1_sticky;
            end
            default: w_next = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v2  <= 1'b0;
            r_out <= '0;
        end else if (w_s2_load) begin
            r_v2  <= r_v1;
            r_out <= w_next;
        end
    end

    assign o_valid     = r_v2;
    assign o_sign      = r_out.sign;
    assign o_exp       = r_out.exp;
    assign o_mant      = r_out.mant;
    assign o_sticky    = r_out.sticky;
    assign o_zero      = r_out.zero;
    assign o_underflow = r_out.uf;
    assign o_overflow  = r_out.of;

endmodule
